// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : controller_pkg
// Brief    : Shared encodings for the multi-cycle RV32I control unit: FSM
//            state codes, ALUOp enum, opcodes and datapath select values.
// Revision : 1.0 - initial release
// ============================================================================
package controller_pkg;

  // Main FSM state codes
  typedef logic [3:0] state_t;
  localparam state_t c_st_fetch    = 4'd0;
  localparam state_t c_st_decode   = 4'd1;
  localparam state_t c_st_memadr   = 4'd2;
  localparam state_t c_st_memread  = 4'd3;
  localparam state_t c_st_memwb    = 4'd4;
  localparam state_t c_st_memwrite = 4'd5;
  localparam state_t c_st_executer = 4'd6;
  localparam state_t c_st_executei = 4'd7;
  localparam state_t c_st_aluwb    = 4'd8;
  localparam state_t c_st_jal      = 4'd9;
  localparam state_t c_st_beq      = 4'd10;

  // Coarse ALU operation requested by the main FSM
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // Opcodes (Instr[6:0])
  localparam logic [6:0] c_op_lw     = 7'b0000011;
  localparam logic [6:0] c_op_sw     = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  // ALU operand A select
  localparam logic [1:0] c_srca_pc    = 2'b00;
  localparam logic [1:0] c_srca_oldpc = 2'b01;
  localparam logic [1:0] c_srca_a     = 2'b10;

  // ALU operand B select
  localparam logic [1:0] c_srcb_wdata = 2'b00;
  localparam logic [1:0] c_srcb_imm   = 2'b01;
  localparam logic [1:0] c_srcb_four  = 2'b10;

  // Result bus select
  localparam logic [1:0] c_res_aluout    = 2'b00;
  localparam logic [1:0] c_res_data      = 2'b01;
  localparam logic [1:0] c_res_aluresult = 2'b10;

  // Immediate format select
  localparam logic [1:0] c_imm_i = 2'b00;
  localparam logic [1:0] c_imm_s = 2'b01;
  localparam logic [1:0] c_imm_b = 2'b10;
  localparam logic [1:0] c_imm_j = 2'b11;

  // ALU control codes
  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_xor = 3'b100;
  localparam logic [2:0] c_alu_slt = 3'b101;

endpackage : controller_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Brief    : Combinational map from (ALUOp, funct3, funct7, OP[5]) to the
//            3-bit ALUControl code.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  // Translate the FSM's coarse request into the concrete ALU operation
  always_comb begin
    alucontrol = c_alu_add;
    case (aluop)
      ALUOP_SUB: alucontrol = c_alu_sub;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only register-register forms with funct7 set subtract; addi never does
          3'b000:  alucontrol = (op5 && funct7) ? c_alu_sub : c_alu_add;
          3'b010:  alucontrol = c_alu_slt;
          3'b100:  alucontrol = c_alu_xor;
          3'b110:  alucontrol = c_alu_or;
          3'b111:  alucontrol = c_alu_and;
          default: alucontrol = c_alu_add;
        endcase
      end
      default: alucontrol = c_alu_add;
    endcase
  end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_controller
// Brief    : Moore main FSM plus instruction / ALU decode for the multi-cycle
//            RV32I datapath. Sequences fetch, decode, execute, memory and
//            writeback and drives every datapath select and write enable.
// Config   : MCC_BNE_EN - when defined, branch funct3=001 (bne) inverts the
//            Zero condition and funct3 other than 000/001 never branches.
// Revision : 1.0 - initial release
// ============================================================================
module multi_cycle_controller
  import controller_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OP,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       Retire,
  output logic       Illegal
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_cur;
  aluop_e     w_aluop;
  logic       w_pcupdate;
  logic       w_branch;
  logic       w_taken;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_irwrite;
  logic       w_retire;
  logic       w_illegal;

  // While reset is held the selects present FETCH values whatever the
  // register holds, so an abandoned instruction never leaks onto the bus.
  assign w_cur = RESET ? r_state : c_st_fetch;

  // State register; reset returns to FETCH
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= c_st_fetch;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state sequencing; DECODE dispatches on opcode
  always_comb begin
    w_next    = c_st_fetch;
    w_illegal = 1'b0;
    case (r_state)
      c_st_fetch: w_next = c_st_decode;
      c_st_decode: begin
        case (OP)
          c_op_lw, c_op_sw: w_next = c_st_memadr;
          c_op_rtype:       w_next = c_st_executer;
          c_op_itype:       w_next = c_st_executei;
          c_op_jal:         w_next = c_st_jal;
          c_op_branch:      w_next = c_st_beq;
          default: begin
            w_next    = c_st_fetch;
            w_illegal = 1'b1;
          end
        endcase
      end
      c_st_memadr:   w_next = (OP == c_op_lw) ? c_st_memread : c_st_memwrite;
      c_st_memread:  w_next = c_st_memwb;
      c_st_executer: w_next = c_st_aluwb;
      c_st_executei: w_next = c_st_aluwb;
      c_st_jal:      w_next = c_st_aluwb;
      default:       w_next = c_st_fetch;
    endcase
  end

  // Moore outputs per state; unused selects default to 00
  always_comb begin
    ALUSrcA    = c_srca_pc;
    ALUSrcB    = c_srcb_wdata;
    ResultSrc  = c_res_aluout;
    AdrSrc     = 1'b0;
    w_aluop    = ALUOP_ADD;
    w_pcupdate = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_retire   = 1'b0;
    case (w_cur)
      c_st_fetch: begin
        ALUSrcB    = c_srcb_four;
        ResultSrc  = c_res_aluresult;
        w_irwrite  = 1'b1;
        w_pcupdate = 1'b1;
      end
      c_st_decode: begin
        // Branch target is precomputed into ALUOut here
        ALUSrcA = c_srca_oldpc;
        ALUSrcB = c_srcb_imm;
      end
      c_st_memadr: begin
        ALUSrcA = c_srca_a;
        ALUSrcB = c_srcb_imm;
      end
      c_st_memread: begin
        AdrSrc = 1'b1;
      end
      c_st_memwb: begin
        ResultSrc  = c_res_data;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      c_st_memwrite: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = 1'b1;
      end
      c_st_executer: begin
        ALUSrcA = c_srca_a;
        w_aluop = ALUOP_FUNCT;
      end
      c_st_executei: begin
        ALUSrcA = c_srca_a;
        ALUSrcB = c_srcb_imm;
        w_aluop = ALUOP_FUNCT;
      end
      c_st_aluwb: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      c_st_jal: begin
        ALUSrcA    = c_srca_oldpc;
        ALUSrcB    = c_srcb_four;
        w_pcupdate = 1'b1;
      end
      c_st_beq: begin
        ALUSrcA  = c_srca_a;
        w_aluop  = ALUOP_SUB;
        w_branch = 1'b1;
        w_retire = 1'b1;
      end
      default: begin
        ALUSrcA = c_srca_pc;
      end
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (OP)
      c_op_sw:     ImmSrc = c_imm_s;
      c_op_branch: ImmSrc = c_imm_b;
      c_op_jal:    ImmSrc = c_imm_j;
      default:     ImmSrc = c_imm_i;
    endcase
  end

`ifdef MCC_BNE_EN
  // Branch condition: beq on Zero, bne on not-Zero, others never taken
  always_comb begin
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      default: w_taken = 1'b0;
    endcase
  end
`else
  // Every branch form is treated as beq
  assign w_taken = Zero;
`endif

  alu_decoder u_alu_decoder (
    .aluop      (w_aluop),
    .funct3     (funct3),
    .funct7     (funct7),
    .op5        (OP[5]),
    .alucontrol (ALUControl)
  );

  // Write enables and pulses are suppressed for the whole reset cycle
  assign PCWrite  = RESET & (w_pcupdate | (w_branch & w_taken));
  assign MemWrite = RESET & w_memwrite;
  assign RegWrite = RESET & w_regwrite;
  assign IRWrite  = RESET & w_irwrite;
  assign Retire   = RESET & w_retire;
  assign Illegal  = RESET & w_illegal;

endmodule : multi_cycle_controller
`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_controller
// Brief    : Self-checking bench for multi_cycle_controller. Each instruction
//            is described by its opcode class and a step index; the expected
//            control word for every cycle is derived from that description.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_controller;

  logic       CLK;
  logic       RESET;
  logic [6:0] OP;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       AdrSrc;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       Retire;
  logic       Illegal;

  int checks   = 0;
  int failures = 0;

  multi_cycle_controller dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .OP         (OP),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .AdrSrc     (AdrSrc),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .Retire     (Retire),
    .Illegal    (Illegal)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Instruction classes
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BR = 5, K_ILL = 6;

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1101111: return K_JAL;
      7'b1100011: return K_BR;
      default:    return K_ILL;
    endcase
  endfunction

  // Cycles from FETCH to last state inclusive
  function automatic int cycles_of(input int k);
    case (k)
      K_LW:    return 5;
      K_SW:    return 4;
      K_R:     return 4;
      K_I:     return 4;
      K_JAL:   return 4;
      K_BR:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (classify(op))
      K_SW:    return 2'b01;
      K_BR:    return 2'b10;
      K_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (op[5] && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd4:    return 3'b100;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
`ifdef MCC_BNE_EN
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    return 1'b0;
`else
    return z;
`endif
  endfunction

  // Expected control word {A,B,Res,Imm,ALU,Adr,PCW,MW,RW,IRW,Ret,Ill}
  function automatic logic [17:0] expect_word(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7, input logic z,
                                              input int step, input logic rst_n);
    logic [1:0] a, b, res;
    logic [2:0] alu;
    logic adr, pcw, mw, rw, irw, ret, ill;
    int k;
    k = classify(op);
    a = 2'b00; b = 2'b00; res = 2'b00; alu = 3'b000;
    adr = 0; pcw = 0; mw = 0; rw = 0; irw = 0; ret = 0; ill = 0;
    if (!rst_n || step == 0) begin
      b = 2'b10; res = 2'b10; irw = 1; pcw = 1;
    end else if (step == 1) begin
      a = 2'b01; b = 2'b01; ill = (k == K_ILL);
    end else begin
      case (k)
        K_LW: begin
          if (step == 2) begin a = 2'b10; b = 2'b01; end
          else if (step == 3) adr = 1;
          else begin res = 2'b01; rw = 1; ret = 1; end
        end
        K_SW: begin
          if (step == 2) begin a = 2'b10; b = 2'b01; end
          else begin adr = 1; mw = 1; ret = 1; end
        end
        K_R, K_I: begin
          if (step == 2) begin
            a = 2'b10; b = (k == K_I) ? 2'b01 : 2'b00; alu = funct_alu(op, f3, f7);
          end else begin rw = 1; ret = 1; end
        end
        K_JAL: begin
          if (step == 2) begin a = 2'b01; b = 2'b10; pcw = 1; end
          else begin rw = 1; ret = 1; end
        end
        K_BR: begin
          a = 2'b10; alu = 3'b001; ret = 1; pcw = branch_taken(f3, z);
        end
        default: ;
      endcase
    end
    if (!rst_n) begin
      pcw = 0; mw = 0; rw = 0; irw = 0; ret = 0; ill = 0;
    end
    return {a, b, res, imm_of(op), alu, adr, pcw, mw, rw, irw, ret, ill};
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    obs = {ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, AdrSrc,
           PCWrite, MemWrite, RegWrite, IRWrite, Retire, Illegal};
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Run one instruction from FETCH. zmode 0/1 fixes Zero, 2 randomizes it each
  // cycle. abort_at >= 0 asserts reset in that step and abandons the rest.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int zmode, input int abort_at);
    int n;
    OP = op; funct3 = f3; funct7 = f7;
    n = cycles_of(classify(op));
    for (int s = 0; s < n; s++) begin
      Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (s == abort_at) RESET = 1'b0;
      @(negedge CLK);
      check($sformatf("%s step%0d%s", name, s, (s == abort_at) ? " rst" : ""),
            expect_word(op, f3, f7, Zero, s, RESET));
      @(posedge CLK);
      #1;
      if (s == abort_at) begin
        RESET = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [6:0] rop;
    logic [6:0] legal_ops [6];
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

    RESET = 1'b0; OP = 7'b0000011; funct3 = 3'd0; funct7 = 1'b0; Zero = 1'b0;

    // Three reset cycles: FETCH selects, no enables
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("reset%0d", i), expect_word(OP, funct3, funct7, Zero, 0, 1'b0));
      @(posedge CLK);
      #1;
    end
    RESET = 1'b1;

    // Directed sequence
    run_instr("lw",        7'b0000011, 3'd2, 1'b0, 2, -1);
    run_instr("sub",       7'b0110011, 3'd0, 1'b1, 2, -1);
    run_instr("addi_f7",   7'b0010011, 3'd0, 1'b1, 2, -1);
    run_instr("beq_z1",    7'b1100011, 3'd0, 1'b0, 1, -1);
    run_instr("beq_z0",    7'b1100011, 3'd0, 1'b0, 0, -1);
    run_instr("bne_z1",    7'b1100011, 3'd1, 1'b0, 1, -1);
    run_instr("bne_z0",    7'b1100011, 3'd1, 1'b0, 0, -1);
    run_instr("br_f3_4",   7'b1100011, 3'd4, 1'b0, 1, -1);
    run_instr("illegal",   7'b1111111, 3'd0, 1'b0, 2, -1);
    run_instr("jal",       7'b1101111, 3'd0, 1'b0, 2, -1);
    run_instr("sw_rst",    7'b0100011, 3'd2, 1'b0, 2, 3);
    run_instr("after_rst", 7'b0110011, 3'd7, 1'b0, 2, -1);

    // Randomized instruction stream with occasional mid-instruction reset
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rop = 7'($urandom);
      end else begin
        rop = legal_ops[$urandom_range(0, 5)];
      end
      run_instr($sformatf("rnd%0d", i), rop, 3'($urandom), 1'($urandom), 2,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_multi_cycle_controller
`default_nettype wire
